// File: rtl/noc_dest_router.sv
// Destination router: queues the merged packet stream in a small FIFO and steers the
// head packet to one of NUM_OUT ports, dropping and counting out-of-range destinations.
module noc_dest_router #(
    parameter int unsigned WIDTH    = 33,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NUM_OUT  = 4,
    parameter int unsigned DEST_LSB = 30,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PtrW-1:0]   wrPtrQ, wrPtrD;
    logic [PtrW-1:0]   rdPtrQ, rdPtrD;
    logic [CountW-1:0] countQ, countD;
    logic [CNT_W-1:0]  dropCntQ, dropCntD;

    logic [WIDTH-1:0]  head;
    logic [2:0]        dest;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;

    assign empty    = (countQ == '0);
    // Ready depends on occupancy only, so a full FIFO stalls upstream one cycle after a pop.
    assign in_ready = (countQ != CountW'(DEPTH));
    assign push     = in_valid && in_ready;

    assign head     = mem[rdPtrQ];
    assign dest     = head[DEST_LSB+2:DEST_LSB];
    assign out_data = empty ? '0 : head;

    always_comb begin
        out_valid = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (!empty && (dest == 3'(i))) begin
                out_valid[i] = 1'b1;
            end
        end
    end

    // A non-empty head that matches no port has an out-of-range destination.
    assign drop = !empty && (out_valid == '0);
    assign pop  = drop || (|(out_valid & out_ready));

    always_comb begin
        wrPtrD   = wrPtrQ;
        rdPtrD   = rdPtrQ;
        countD   = countQ;
        dropCntD = dropCntQ;
        if (push) begin
            wrPtrD = wrPtrQ + PtrW'(1);
        end
        if (pop) begin
            rdPtrD = rdPtrQ + PtrW'(1);
        end
        if (push && !pop) begin
            countD = countQ + CountW'(1);
        end else if (pop && !push) begin
            countD = countQ - CountW'(1);
        end
        if (drop && (dropCntQ != '1)) begin
            dropCntD = dropCntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrQ   <= '0;
            rdPtrQ   <= '0;
            countQ   <= '0;
            dropCntQ <= '0;
        end else begin
            wrPtrQ   <= wrPtrD;
            rdPtrQ   <= rdPtrD;
            countQ   <= countD;
            dropCntQ <= dropCntD;
        end
    end

    // Storage is write-enabled only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtrQ] <= in_data;
        end
    end

    assign fifo_count = countQ;
    assign drop_cnt   = dropCntQ;

endmodule

// File: tb/tb_noc_dest_router.sv
// Directed bench for noc_dest_router: routing, back-pressure, drops, saturation and
// asynchronous reset, each against hand-computed expected values.
module tb_noc_dest_router;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [32:0] out_data;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int nVec;
    int nMiss;

    noc_dest_router #(
        .WIDTH   (33),
        .DEPTH   (4),
        .NUM_OUT (4),
        .DEST_LSB(30),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fifo_count(fifo_count),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] mkPkt(input logic [2:0] d, input logic [29:0] payload);
        return {d, payload};
    endfunction

    logic [32:0] pkt;

    initial begin
        nVec      = 0;
        nMiss     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state
        checkVal("rst_in_ready", in_ready, 1);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_count", fifo_count, 0);
        checkVal("rst_drop", drop_cnt, 0);
        checkVal("rst_out_data", out_data, 0);

        // Single packet, dest=1, all ports ready
        in_valid  = 1'b1;
        in_data   = 33'h040000005;
        out_ready = 4'b1111;
        tick();
        in_valid = 1'b0;
        #1;
        checkVal("single_valid", out_valid, 4'b0010);
        checkVal("single_data", out_data, 33'h040000005);
        checkVal("single_count", fifo_count, 1);
        tick();
        checkVal("single_pop_count", fifo_count, 0);
        checkVal("single_pop_valid", out_valid, 0);

        // Fill with dest 0..3 while stalled
        out_ready = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            in_valid = 1'b1;
            in_data  = mkPkt(3'(d), 30'(d + 16));
            tick();
        end
        in_valid = 1'b0;
        #1;
        checkVal("fill_count", fifo_count, 4);
        checkVal("fill_in_ready", in_ready, 0);
        checkVal("fill_head_valid", out_valid, 4'b0001);
        out_ready = 4'b1111;
        #1;
        checkVal("drain_first_in_ready", in_ready, 0);
        for (int d = 0; d < 4; d++) begin
            pkt = mkPkt(3'(d), 30'(d + 16));
            checkVal("drain_valid", out_valid, 64'(4'b0001 << d));
            checkVal("drain_data", out_data, pkt);
            tick();
            checkVal("drain_count", fifo_count, 64'(3 - d));
            if (d == 0) checkVal("drain_in_ready_rise", in_ready, 1);
        end

        // Head dest=2 blocked by its own port; other ports' ready ignored
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = mkPkt(3'd2, 30'h2AAA_AAAA);
        tick();
        in_valid = 1'b0;
        #1;
        checkVal("block_valid", out_valid, 4'b0100);
        checkVal("block_data", out_data, mkPkt(3'd2, 30'h2AAA_AAAA));
        tick();
        checkVal("block_hold_valid", out_valid, 4'b0100);
        checkVal("block_hold_data", out_data, mkPkt(3'd2, 30'h2AAA_AAAA));
        checkVal("block_hold_count", fifo_count, 1);
        out_ready = 4'b0100;
        tick();
        checkVal("block_release_count", fifo_count, 0);

        // Drop of dest=6 followed by dest=0
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = mkPkt(3'd6, 30'h66);
        tick();
        in_data = mkPkt(3'd0, 30'h77);
        #1;
        checkVal("drop_valid", out_valid, 0);
        checkVal("drop_count_before", fifo_count, 1);
        tick();
        in_valid = 1'b0;
        #1;
        checkVal("drop_cnt_one", drop_cnt, 1);
        checkVal("drop_next_valid", out_valid, 4'b0001);
        checkVal("drop_next_data", out_data, mkPkt(3'd0, 30'h77));
        tick();
        checkVal("drop_next_pop", fifo_count, 0);

        // Saturation: 300 more drops on top of the one already counted
        in_valid = 1'b1;
        in_data  = mkPkt(3'd7, 30'h1);
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkVal("drop_saturate", drop_cnt, 8'hFF);
        checkVal("drop_sat_count", fifo_count, 0);

        // Asynchronous reset with 3 queued packets
        out_ready = 4'b0000;
        for (int d = 0; d < 3; d++) begin
            in_valid = 1'b1;
            in_data  = mkPkt(3'(d), 30'(d + 32));
            tick();
        end
        in_valid = 1'b0;
        #1;
        checkVal("pre_rst_count", fifo_count, 3);
        #1;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_count", fifo_count, 0);
        checkVal("async_rst_valid", out_valid, 0);
        checkVal("async_rst_drop", drop_cnt, 0);
        checkVal("async_rst_data", out_data, 0);
        #2;
        rst_n = 1'b1;
        tick();
        checkVal("post_rst_in_ready", in_ready, 1);
        out_ready = 4'b1000;
        in_valid  = 1'b1;
        in_data   = mkPkt(3'd3, 30'h1234);
        tick();
        in_valid = 1'b0;
        #1;
        checkVal("post_rst_valid", out_valid, 4'b1000);
        checkVal("post_rst_data", out_data, mkPkt(3'd3, 30'h1234));
        tick();
        checkVal("post_rst_pop", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/noc_dest_router.md
Name: noc_dest_router

Overview:
- Clocked, buffered consumer placed directly downstream of the two-input arbiter-merge.
- Accepts the merged 33-bit packet stream through a valid/ready port and queues it in a small FIFO.
- Decodes a destination field in each packet and steers the packet to one of NUM_OUT output ports.
- Packets with an out-of-range destination are dropped and counted.

Parameters:
- WIDTH, 33, packet width in bits.
- DEPTH, 4, input FIFO depth in entries; must be a power of 2 and at least 2.
- NUM_OUT, 4, number of output ports; range 2..8.
- DEST_LSB, 30, LSB of the 3-bit destination field, pkt[DEST_LSB+2:DEST_LSB].
- CNT_W, 8, width of the drop counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream packet valid.
- in_ready, output, 1, router can accept a packet.
- in_data, input, WIDTH, upstream packet.
- out_valid, output, NUM_OUT, one-hot per-port valid.
- out_ready, input, NUM_OUT, per-port ready.
- out_data, output, WIDTH, head packet, shared across all ports.
- fifo_count, output, $clog2(DEPTH)+1, current occupancy.
- drop_cnt, output, CNT_W, number of dropped packets; saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empties; read and write pointers go to 0.
  - fifo_count=0, drop_cnt=0, out_valid=0, in_ready=1 once rst_n is high.
  - out_data=0 while the FIFO is empty.
  - A reset mid-transfer discards all queued packets. No partial transfer survives reset.
- Enqueue:
  - A packet is accepted on any rising edge where in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH). It depends on occupancy only, not on the same-cycle dequeue.
  - When full, upstream stalls one extra cycle even if the head leaves that cycle.
- Head decode (combinational from FIFO head):
  - dest = head[DEST_LSB+2:DEST_LSB].
  - If the FIFO is not empty and dest < NUM_OUT: out_valid = one-hot(dest). All other bits are 0.
  - If the FIFO is empty: out_valid = 0.
- Latency:
  - A packet accepted at edge N is on out_data with out_valid set during cycle N+1, i.e. visible after edge N.
  - This holds when the FIFO was empty before edge N.
  - There is no combinational path from in_* to out_*.
- Dequeue:
  - The head pops on the edge where out_valid[dest] && out_ready[dest].
  - out_ready bits of other ports are ignored.
  - Head-of-line blocking is intentional: a stalled port blocks all ports.
  - At most one pop per cycle.
- Drop:
  - If the FIFO is not empty and dest >= NUM_OUT, the head pops unconditionally on the next edge.
  - out_valid stays 0 for that packet.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - A drop occupies one cycle.
- Simultaneous push and pop:
  - Allowed when 0 < count < DEPTH; fifo_count is unchanged.
  - Push into an empty FIFO is not bypassed; the pop occurs at the earliest the next cycle.
- Pointers:
  - $clog2(DEPTH) bits each, wrapping naturally mod DEPTH.
  - Full/empty is derived from fifo_count.
- Ordering: packets leave, or are dropped, in strict arrival order.
- Data stability: out_data and out_valid hold stable while out_valid[dest]=1 and out_ready[dest]=0.
- Synthesis: no latches. All flops reset asynchronously except the FIFO storage array, which is write-enabled only.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0000, fifo_count=0, drop_cnt=0.
- Single packet 0x0_4000_0005 (dest=1) with all out_ready=1 → out_valid=0010 in the cycle after accept, out_data=0x040000005, popped on the next edge, count returns to 0.
- Four back-to-back packets with dest=0,1,2,3 and out_ready=0000 → fifo_count=4, in_ready=0. Then assert out_ready=1111 → packets emerge in order, one per cycle, out_valid=0001,0010,0100,1000. in_ready rises the cycle after the first pop.
- Head dest=2 with out_ready=1011 → out_valid=0100 held with stable data, no pop. Raising out_ready[2] → pop on the following edge.
- Packet with dest=6 (NUM_OUT=4), followed by a packet with dest=0 → out_valid stays 0 for the first, drop_cnt=1, and the second packet is delivered one cycle later on port 0.
- Assert rst_n low asynchronously mid-cycle with 3 queued packets → fifo_count=0, out_valid=0 immediately without waiting for a clock. After release, a new packet routes normally.
